// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among NUM_REQ requesters.
// Optional macro FP_ADD_ARB_SUB_EN adds a per-requester req_sub port so the shared adder computes A-B.

module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        w_swap;
    logic        w_eff_sub;
    logic [31:0] w_l;
    logic [31:0] w_s;
    logic [23:0] w_ml;
    logic [23:0] w_ms;
    logic [7:0]  w_d;
    logic [49:0] w_ms_sh;
    logic [26:0] w_ms_al;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic signed [9:0] w_exp;
    logic        w_inc;
    logic [24:0] w_rnd;
    logic [22:0] w_frac;
    logic        w_nan;

    // Order operands by magnitude so only the smaller one is ever shifted; denormals flush to zero.
    assign w_swap    = b[30:0] > a[30:0];
    assign w_l       = w_swap ? b : a;
    assign w_s       = w_swap ? a : b;
    assign w_ml      = (|w_l[30:23]) ? {1'b1, w_l[22:0]} : 24'd0;
    assign w_ms      = (|w_s[30:23]) ? {1'b1, w_s[22:0]} : 24'd0;
    assign w_d       = w_l[30:23] - w_s[30:23];
    assign w_ms_sh   = {w_ms, 26'd0} >> w_d;
    assign w_ms_al   = {w_ms_sh[49:24], |w_ms_sh[23:0]};
    assign w_eff_sub = w_l[31] ^ w_s[31];
    assign w_sum     = w_eff_sub ? ({1'b0, w_ml, 3'd0} - {1'b0, w_ms_al})
                                 : ({1'b0, w_ml, 3'd0} + {1'b0, w_ms_al});
    assign w_nan     = ((a[30:23] == 8'hFF) && (|a[22:0])) || ((b[30:23] == 8'hFF) && (|b[22:0])) ||
                       ((a[30:23] == 8'hFF) && (b[30:23] == 8'hFF) && (a[31] != b[31]));

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
        end
    end

    always_comb begin
        w_norm = '0;
        w_exp  = '0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = $signed({2'b00, w_l[30:23]}) + 10'sd1;
        end else begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = $signed({2'b00, w_l[30:23]}) - $signed({5'b00000, w_lz});
        end
        // Round to nearest, ties to even, using guard plus sticky.
        w_inc = w_norm[2] & ((|w_norm[1:0]) | w_norm[3]);
        w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
        w_frac = w_rnd[22:0];
        if (w_rnd[24]) begin
            w_exp  = w_exp + 10'sd1;
            w_frac = w_rnd[23:1];
        end
        if (w_nan)
            y = 32'h7FC0_0000;
        else if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF))
            y = {w_l[31], 8'hFF, 23'd0};
        else if (w_sum == 28'd0)
            y = {a[31] & b[31], 31'd0};
        else if (w_exp <= 10'sd0)
            y = {w_l[31], 31'd0};
        else if (w_exp >= 10'sd255)
            y = {w_l[31], 8'hFF, 23'd0};
        else
            y = {w_l[31], w_exp[7:0], w_frac};
    end
endmodule

module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
`ifdef FP_ADD_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]     req_sub,
`endif
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_id_q;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;
    logic [31:0]     w_a [NUM_REQ];
    logic [31:0]     w_b [NUM_REQ];
    logic [31:0]     w_sum;
    logic [ID_W-1:0] w_grant;
    logic            w_found;
    logic            w_accept;
    int              w_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[32*gi +: 32];
`ifdef FP_ADD_ARB_SUB_EN
            assign w_b[gi] = {req_b[32*gi+31] ^ req_sub[gi], req_b[32*gi +: 31]};
`else
            assign w_b[gi] = req_b[32*gi +: 32];
`endif
        end
    endgenerate

    // Scan downward in offset so the last hit is the first valid at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    fp_adder u_fp_adder (
        .a (r_op_a),
        .b (r_op_b),
        .y (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_id_q     <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op_a   <= w_a[w_grant];
                r_op_b   <= w_b[w_grant];
                r_id_q   <= w_grant;
                r_rr_ptr <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
            end
            if (r_state == S_EXEC) begin
                r_rsp_data <= w_sum;
                r_rsp_id   <= r_id_q;
            end
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized scoreboard bench for fp_add_arbiter; expected sums come from real arithmetic on exactly representable operands.
`timescale 1ns/1ps
module tb_fp_add_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
`ifdef FP_ADD_ARB_SUB_EN
    logic [N-1:0]     req_sub;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef FP_ADD_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;

    int     errors = 0;
    int     checks = 0;
    real    va [N];
    real    vb [N];
    logic   sb [N];
    exp_t   exp_q [$];
    int     m_phase = 0;
    int     m_ptr = 0;
    int     m_g;
    bit     m_after_rst = 1'b1;
    logic [N-1:0] m_exp_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Repack an exactly representable real into single precision.
    function automatic logic [31:0] to_single(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52];
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic real rand_val();
        real v = real'($urandom_range(0, 1023));
        int  k = int'($urandom_range(0, 8)) - 4;
        for (int i = 0; i < k; i++) v = v * 2.0;
        for (int i = 0; i < -k; i++) v = v / 2.0;
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic load(input int i, input real a, input real b, input logic s);
        va[i] = a;
        vb[i] = b;
        sb[i] = s;
        req_a[32*i +: 32] = to_single(a);
        req_b[32*i +: 32] = to_single(b);
`ifdef FP_ADD_ARB_SUB_EN
        req_sub[i] = s;
`endif
    endtask

    function automatic real model_result(input int i);
`ifdef FP_ADD_ARB_SUB_EN
        if (sb[i]) return va[i] - vb[i];
`endif
        return va[i] + vb[i];
    endfunction

    // Reference model: round-robin grant choice, phase timing, expected result pushed on acceptance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ptr = 0;
            m_phase = 0;
            m_after_rst = 1'b1;
        end else begin
            if (m_after_rst) begin
                check("reset_rsp_data", rsp_data, 0);
                check("reset_rsp_id", rsp_id, 0);
                m_after_rst = 1'b0;
            end
            case (m_phase)
                0: begin
                    m_g = -1;
                    for (int k = 0; k < N; k++) begin
                        if (req_valid[(m_ptr + k) % N]) begin
                            m_g = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_exp_ready = '0;
                    if (m_g >= 0) m_exp_ready[m_g] = 1'b1;
                    check("idle_grant", req_ready, m_exp_ready);
                    check("idle_busy", busy, 0);
                    check("idle_rsp_valid", rsp_valid, 0);
                    if (m_g >= 0) begin
                        exp_q.push_back(exp_t'{IDW'(m_g), to_single(model_result(m_g))});
                        m_ptr = (m_g + 1) % N;
                        m_phase = 1;
                    end
                end
                1: begin
                    check("exec_ready", req_ready, 0);
                    check("exec_rsp_valid", rsp_valid, 0);
                    check("exec_busy", busy, 1);
                    m_phase = 2;
                end
                default: begin
                    check("resp_rsp_valid", rsp_valid, 1);
                    check("resp_ready", req_ready, 0);
                    check("resp_busy", busy, 1);
                    if (rsp_ready) m_phase = 0;
                end
            endcase
        end
    end

    // Scoreboard monitor: compare every presented response against the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: actual id %0d data %h, required no response", rsp_id, rsp_data);
            end else begin
                check("rsp_data", rsp_data, exp_q[0].data);
                check("rsp_id", rsp_id, exp_q[0].id);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    logic [N-1:0] hs;
    bit           fair;
    bit           stall;

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef FP_ADD_ARB_SUB_EN
        req_sub   = '0;
`endif
        for (int i = 0; i < N; i++) load(i, 0.0, 0.0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request from requester 2: 1.0 + 2.0 with fixed latency.
        load(2, 1.0, 2.0, 1'b0);
        req_valid[2] = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_ready", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_data", rsp_data, 32'h4040_0000);
        check("single_rsp_id", rsp_id, 2);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            hs = rst ? '0 : (req_valid & req_ready);
            @(posedge clk);
            #1;
            fair  = (cyc >= 300) && (cyc < 500);
            stall = (cyc >= 700) && (cyc < 900);
            rst   = !fair && (cyc > 50) && ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = fair || (hs[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0));
                    load(i, rand_val(), rand_val(), 1'($urandom_range(0, 1)));
                end else if (!fair && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (fair)       rsp_ready = 1'b1;
            else if (stall) rsp_ready = ($urandom_range(0, 7) == 0);
            else            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int w = 0; w < 20 && busy; w++) @(posedge clk);
        @(negedge clk);
        check("drain_busy", busy, 0);
        check("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
